// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state encoding, index width and sample field helpers for fft_out_serializer
package fft_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sample layout: {re, im}, each half of the sample width.
  function automatic int re_hi(input int msb);
    return msb - 1;
  endfunction

  function automatic int re_lo(input int msb);
    return msb / 2;
  endfunction

  function automatic int im_hi(input int msb);
    return msb / 2 - 1;
  endfunction

  function automatic int im_lo(input int msb);
    return 0 * msb;
  endfunction

endpackage

// File: rtl/fft_out_serializer_if.sv
// rtl/fft_out_serializer_if.sv - valid/ready sample stream between serializer and consumer
interface fft_out_serializer_if
  import fft_pkg::*;
#(
  parameter int N   = 32,
  parameter int MSB = 16
);

  logic                  out_valid;
  logic                  out_ready;
  logic [MSB-1:0]        out_data;
  logic [idx_w(N)-1:0]   out_index;
  logic                  out_last;

  modport master (
    output out_valid, out_data, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_index, out_last,
    output out_ready
  );

endinterface

// File: rtl/fft_abs_sum.sv
// rtl/fft_abs_sum.sv - combinational |re|+|im| of one sample, unsigned, no saturation
module fft_abs_sum
  import fft_pkg::*;
#(
  parameter int MSB = 16
) (
  input  logic [MSB-1:0] i_sample,
  output logic [MSB/2:0] o_mag
);

  localparam int H     = MSB / 2;
  localparam int RE_HI = re_hi(MSB);
  localparam int RE_LO = re_lo(MSB);
  localparam int IM_HI = im_hi(MSB);
  localparam int IM_LO = im_lo(MSB);

  // One extra bit so the negated most-negative value stays positive.
  logic [H:0] w_re;
  logic [H:0] w_im;
  logic [H:0] w_re_abs;
  logic [H:0] w_im_abs;

  assign w_re     = {i_sample[RE_HI], i_sample[RE_HI:RE_LO]};
  assign w_im     = {i_sample[IM_HI], i_sample[IM_HI:IM_LO]};
  assign w_re_abs = w_re[H] ? (~w_re + 1'b1) : w_re;
  assign w_im_abs = w_im[H] ? (~w_im + 1'b1) : w_im;
  assign o_mag    = w_re_abs + w_im_abs;

endmodule

// File: rtl/fft_out_serializer.sv
// rtl/fft_out_serializer.sv - captures an N-sample FFT result and streams it one sample per transfer
// Optional magnitude output enabled by FFT_OUT_MAG_EN.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int N   = 32,
  parameter int MSB = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*MSB-1:0]       fft_data_in,
  input  logic                   calc_finish,
  input  logic                   overrun_clr,
  fft_out_serializer_if.master   stream,
  output logic                   frame_done,
  output logic                   overrun
`ifdef FFT_OUT_MAG_EN
  ,
  output logic [MSB/2:0]         mag_out
`endif
);

  localparam int                 IDX_W    = idx_w(N);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_calc_prev;
  logic [N*MSB-1:0]   r_buf;
  logic               r_frame_done;
  logic               r_overrun;

  logic               w_start;
  logic               w_xfer;
  logic [MSB-1:0]     w_sample;

  assign w_start  = calc_finish & ~r_calc_prev;
  assign w_xfer   = (r_state == ST_SEND) & stream.out_ready;
  assign w_sample = r_buf[int'(r_idx) * MSB +: MSB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_calc_prev  <= 1'b0;
      r_buf        <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_calc_prev  <= calc_finish;
      r_frame_done <= 1'b0;
      // Clear first so a same-cycle overrun set takes priority.
      if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_buf   <= fft_data_in;
            r_idx   <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_start) begin
            r_overrun <= 1'b1;
          end
          if (w_xfer) begin
            if (r_idx == LAST_IDX) begin
              r_idx        <= '0;
              r_state      <= ST_IDLE;
              r_frame_done <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stream.out_valid = (r_state == ST_SEND);
  assign stream.out_data  = (r_state == ST_SEND) ? w_sample : '0;
  assign stream.out_index = r_idx;
  assign stream.out_last  = (r_state == ST_SEND) && (r_idx == LAST_IDX);
  assign frame_done       = r_frame_done;
  assign overrun          = r_overrun;

`ifdef FFT_OUT_MAG_EN
  fft_abs_sum #(
    .MSB (MSB)
  ) u_abs_sum (
    .i_sample (stream.out_data),
    .o_mag    (mag_out)
  );
`endif

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb/tb_fft_out_serializer.sv - randomized directed bench for fft_out_serializer against a frame-level model
module tb_fft_out_serializer;
  import fft_pkg::*;

  localparam int N   = 32;
  localparam int MSB = 16;

  logic             clk         = 1'b0;
  logic             rst         = 1'b1;
  logic             calc_finish = 1'b0;
  logic             overrun_clr = 1'b0;
  logic [N*MSB-1:0] fft_data_in = '0;
  logic             frame_done;
  logic             overrun;
`ifdef FFT_OUT_MAG_EN
  logic [MSB/2:0]   mag_out;
`endif

  int n_err    = 0;
  int n_checks = 0;

  fft_out_serializer_if #(.N(N), .MSB(MSB)) bus ();

  fft_out_serializer #(
    .N   (N),
    .MSB (MSB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fft_data_in (fft_data_in),
    .calc_finish (calc_finish),
    .overrun_clr (overrun_clr),
    .stream      (bus.master),
    .frame_done  (frame_done),
    .overrun     (overrun)
`ifdef FFT_OUT_MAG_EN
    ,
    .mag_out     (mag_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MSB-1:0] samp(input logic [N*MSB-1:0] d, input int k);
    return d[k*MSB +: MSB];
  endfunction

  function automatic int ref_mag(input logic [MSB-1:0] s);
    byte signed re;
    byte signed im;
    int r;
    int i;
    re = s[15:8];
    im = s[7:0];
    r  = re;
    i  = im;
    return ((r < 0) ? -r : r) + ((i < 0) ? -i : i);
  endfunction

  function automatic logic [N*MSB-1:0] rand_frame();
    logic [N*MSB-1:0] d;
    for (int i = 0; i < N*MSB/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic check_out(input logic [N*MSB-1:0] d, input int k);
    chk($sformatf("out_valid[%0d]", k), bus.out_valid, 1);
    chk($sformatf("out_index[%0d]", k), bus.out_index, k);
    chk($sformatf("out_data[%0d]", k), bus.out_data, samp(d, k));
    chk($sformatf("out_last[%0d]", k), bus.out_last, (k == N-1));
    chk($sformatf("frame_done_mid[%0d]", k), frame_done, 0);
`ifdef FFT_OUT_MAG_EN
    chk($sformatf("mag_out[%0d]", k), mag_out, ref_mag(samp(d, k)));
`endif
  endtask

  task automatic start_frame(input logic [N*MSB-1:0] d);
    fft_data_in = d;
    calc_finish = 1'b1;
    step();
    chk("first_valid", bus.out_valid, 1);
    chk("first_index", bus.out_index, 0);
  endtask

  // mode: 0 ready always high, 1 ready toggles starting high, 2 random ready.
  // hold: calc_finish kept high for this many stream cycles.
  // inj_at: sample index at which a new frame edge arrives (-1 for none).
  task automatic run_frame(input logic [N*MSB-1:0] d, input int mode, input int hold,
                           input int inj_at, input logic inj_clr, output int cycles);
    int  k = 0;
    bit  injected = 0;
    bit  rdy;
    cycles = 0;
    while (k < N && cycles < 2000) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cycles % 2 == 0) : 1'($urandom_range(0, 1));
      bus.out_ready = rdy;
      calc_finish   = (cycles < hold);
      overrun_clr   = 1'b0;
      if (!injected && k == inj_at) begin
        calc_finish = 1'b1;
        fft_data_in = ~d;
        overrun_clr = inj_clr;
        injected    = 1;
      end
      check_out(d, k);
      step();
      cycles++;
      if (rdy) k++;
    end
    calc_finish   = 1'b0;
    overrun_clr   = 1'b0;
    bus.out_ready = 1'b0;
    chk("frame_complete", k, N);
    chk("frame_done_pulse", frame_done, 1);
    chk("valid_low_at_done", bus.out_valid, 0);
  endtask

  initial begin
    logic [N*MSB-1:0] d;
    logic [N*MSB-1:0] d2;
    int cyc;

    bus.out_ready = 1'b0;
    step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_index", bus.out_index, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
`ifdef FFT_OUT_MAG_EN
    chk("rst_mag_out", mag_out, 0);
`endif
    rst = 1'b0;
    step();
    chk("idle_valid", bus.out_valid, 0);

    for (int k = 0; k < N; k++) begin
      logic [7:0] kb;
      kb = k[7:0];
      d[k*MSB +: MSB] = {kb, ~kb};
    end
    start_frame(d);
    run_frame(d, 0, 0, -1, 1'b0, cyc);
    chk("cycles_ready_high", cyc, N);
    step();
    chk("frame_done_one_cycle", frame_done, 0);

    start_frame(d);
    run_frame(d, 1, 0, -1, 1'b0, cyc);
    chk("cycles_ready_toggle", cyc, 2*N - 1);
    step();

    d  = rand_frame();
    d2 = rand_frame();
    start_frame(d);
    run_frame(d, 0, 0, -1, 1'b0, cyc);
    start_frame(d2);
    run_frame(d2, 2, 0, -1, 1'b0, cyc);
    step();

    d = rand_frame();
    start_frame(d);
    run_frame(d, 2, 4, -1, 1'b0, cyc);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("held_no_second_frame", bus.out_valid, 0);
    end
    chk("held_no_overrun", overrun, 0);

    d = rand_frame();
    start_frame(d);
    run_frame(d, 2, 0, 10, 1'b1, cyc);
    chk("overrun_set", overrun, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("overrun_no_second_frame", bus.out_valid, 0);
    end
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("overrun_cleared", overrun, 0);

    d = rand_frame();
    start_frame(d);
    run_frame(d, 0, 0, N-1, 1'b0, cyc);
    chk("overrun_on_last", overrun, 1);
    step();
    chk("last_edge_ignored", bus.out_valid, 0);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("overrun_cleared2", overrun, 0);

`ifdef FFT_OUT_MAG_EN
    d = rand_frame();
    d[15:0] = 16'h807F;
    start_frame(d);
    chk("mag_neg_max", mag_out, 255);
    run_frame(d, 0, 0, -1, 1'b0, cyc);
    step();
    d = rand_frame();
    d[15:0] = 16'hFD05;
    start_frame(d);
    chk("mag_small", mag_out, 8);
    run_frame(d, 0, 0, -1, 1'b0, cyc);
    step();
`endif

    d = rand_frame();
    start_frame(d);
    for (int i = 0; i < 7; i++) begin
      bus.out_ready = 1'b1;
      calc_finish   = (i == 3);
      step();
    end
    calc_finish = 1'b0;
    chk("pre_rst_index", bus.out_index, 7);
    chk("pre_rst_overrun", overrun, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_index", bus.out_index, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_frame_done", frame_done, 0);
      chk("midrst_idle", bus.out_valid, 0);
    end
    d = rand_frame();
    start_frame(d);
    run_frame(d, 2, 0, -1, 1'b0, cyc);
    step();

    for (int f = 0; f < 4; f++) begin
      d = rand_frame();
      start_frame(d);
      run_frame(d, 2, 0, -1, 1'b0, cyc);
      step();
    end
    chk("final_overrun", overrun, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
